dout_serializer: RTL and testbench
==================================

DOUT_SERIALIZER -- requirements
Module: dout_serializer

Interface
REQ-001 SHALL have parameter LANE_W, default 16, the width of one output lane in bits.
REQ-002 SHALL have parameter LANES, default 16, the number of lanes per input word; LANE_W*LANES SHALL equal 256.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_busy  output  1  the input is not accepting a word.
REQ-006 SHALL have port in_vld  input  1  in_data is valid.
REQ-007 SHALL have port in_data  input  256  the upstream result word; lane k is bits [k*LANE_W+LANE_W-1 : k*LANE_W].
REQ-008 SHALL have port out_busy  input  1  downstream stall.
REQ-009 SHALL have port out_vld  output  1  out_data is valid.
REQ-010 SHALL have port out_data  output  LANE_W  the current lane or checksum.
REQ-011 SHALL have port out_idx  output  4  the lane index of the current beat.
REQ-012 SHALL have port out_last  output  1  the final beat of a word.
REQ-013 SHALL have port out_chk  output  1  the current beat is a checksum beat.

Function
REQ-014 SHALL transfer on an input only at a rising edge where in_vld=1 and in_busy=0, and on an output only at a rising edge where out_vld=1 and out_busy=0.
REQ-015 SHALL implement an FSM with states IDLE, SEND and SUM; SUM SHALL exist only with CHECKSUM_EN.
REQ-016 In IDLE, SHALL drive in_busy=0 and out_vld=0, and SHALL on an input transfer capture in_data into a 256-bit hold register, clear the lane counter to 0 and go to SEND.
REQ-017 In SEND, SHALL drive out_vld=1, out_data=lane[counter] taken from the hold register, out_idx=counter and out_chk=0.
REQ-018 On each SEND output transfer, SHALL increment the counter; after lane LANES-1 the counter SHALL wrap to 0.
REQ-019 Latency: a word accepted at edge N SHALL present lane 0 during the cycle following edge N.
REQ-020 While out_busy=1, out_data, out_idx, out_last and out_chk SHALL remain unchanged.
REQ-021 in_busy SHALL be 1 in SEND/SUM, except in the cycle where the final beat transfers, when in_busy SHALL be 0; this is combinational from out_busy.
REQ-022 If a new input transfers on the same edge as the final beat, SHALL load the new word and stay in or enter SEND at lane 0 with no bubble cycle.
REQ-023 If no new input transfers on the final-beat edge, SHALL return to IDLE.
REQ-024 Without CHECKSUM_EN, out_last SHALL be 1 on lane LANES-1, and SEND SHALL be followed by IDLE or SEND after that beat.
REQ-025 in_data SHALL be ignored while in_busy=1.

Reset
REQ-026 While rst=0, SHALL immediately force state=IDLE, counter=0, hold register=0 and checksum=0.
REQ-027 While rst=0, SHALL force outputs out_vld=0, out_data=0, out_idx=0, out_last=0, out_chk=0 and in_busy=0.
REQ-028 Reset asserted mid-word SHALL discard the partial word; after rst is released, the next accepted word SHALL start at lane 0.

Configuration
REQ-029 With macro DOUT_SERIALIZER_CHECKSUM_EN defined, SHALL accumulate a LANE_W-bit checksum, modulo 2^LANE_W, of all lanes of the current word.
REQ-030 With DOUT_SERIALIZER_CHECKSUM_EN defined, after lane LANES-1 transfers SHALL enter SUM and emit one extra beat with out_data=checksum, out_chk=1, out_last=1 and out_idx=0.
REQ-031 With DOUT_SERIALIZER_CHECKSUM_EN defined, out_last SHALL be 0 on lane beats, and the SUM beat SHALL be the final beat for REQ-021 to REQ-023; the checksum SHALL clear when a new word is loaded.
REQ-032 Without DOUT_SERIALIZER_CHECKSUM_EN, SHALL contain no accumulator or SUM state, and SHALL tie out_chk to 0.

Verification
REQ-033 Lanes 0x0001..0x0010 with out_busy=0 -> 16 beats with out_data 1..16 and out_idx 0..15 on consecutive cycles, out_last on beat 16; with the macro, a 17th beat out_data=0x0088 with out_chk=1 and out_last=1.
REQ-034 out_busy=1 for 3 cycles while out_idx=5 -> out_data holds lane 5 stable for 4 cycles, then lane 6 follows.
REQ-035 Two words presented back-to-back with in_vld=1 -> 32 beats (34 with the macro) with no out_vld gap, and in_busy=0 only on each final-beat cycle.
REQ-036 All lanes 0xFFFF with the macro -> checksum beat out_data=0xFFF0 (wrap-around).
REQ-037 rst=0 asserted asynchronously at out_idx=7 -> out_vld=0 and in_busy=0 within the same cycle; the next word after release starts at out_idx=0 with lane 0 data.

Source files
------------

// File: rtl/dout_serializer.sv
// dout_serializer
// Splits each 256-bit upstream result word into LANES beats of LANE_W bits
// and streams them out lane 0 first, with valid/busy handshaking on both sides.
// A new word may be accepted on the same edge as the final beat of the
// current word, so back-to-back words stream with no bubble cycle.
//
// Optional feature: define DOUT_SERIALIZER_CHECKSUM_EN to append one checksum
// beat per word (sum of all lanes, modulo 2^LANE_W). Without it, no
// accumulator or SUM state exists and out_chk is tied to 0.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : asynchronous reset, active low
//   in_busy   : input side not accepting a word
//   in_vld    : in_data valid
//   in_data   : upstream word, lane k = bits [k*LANE_W +: LANE_W]
//   out_busy  : downstream stall
//   out_vld   : out_data valid
//   out_data  : current lane or checksum
//   out_idx   : lane index of the current beat (0 on the checksum beat)
//   out_last  : final beat of a word
//   out_chk   : current beat is the checksum beat
//
// state  | meaning
// IDLE   | no word held, waiting for an input transfer
// SEND   | presenting lane[cnt_q] of the held word
// SUM    | presenting the checksum beat (checksum builds only)
module dout_serializer #(
  parameter int LANE_W = 16,
  parameter int LANES  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      in_busy,
  input  logic                      in_vld,
  input  logic [LANE_W*LANES-1:0]   in_data,
  input  logic                      out_busy,
  output logic                      out_vld,
  output logic [LANE_W-1:0]         out_data,
  output logic [3:0]                out_idx,
  output logic                      out_last,
  output logic                      out_chk
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND
`ifdef DOUT_SERIALIZER_CHECKSUM_EN
    , S_SUM
`endif
  } state_t;

  state_t                    state_q, state_d;
  logic [LANE_W*LANES-1:0]   hold_q;
  logic [3:0]                cnt_q;
  logic [3:0]                cnt_inc;
  logic [LANE_W-1:0]         lane_data;
  logic                      last_lane;
  logic                      load;
  logic                      adv;
`ifdef DOUT_SERIALIZER_CHECKSUM_EN
  logic [LANE_W-1:0]         chk_q;
`endif

  assign lane_data = hold_q[cnt_q*LANE_W +: LANE_W];
  assign last_lane = (cnt_q == 4'(LANES - 1));
  assign cnt_inc   = last_lane ? 4'd0 : cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_busy  = 1'b0;
    out_vld  = 1'b0;
    out_data = '0;
    out_idx  = '0;
    out_last = 1'b0;
    out_chk  = 1'b0;
    load     = 1'b0;
    adv      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          load    = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        out_vld  = 1'b1;
        out_data = lane_data;
        out_idx  = cnt_q;
        in_busy  = 1'b1;
`ifndef DOUT_SERIALIZER_CHECKSUM_EN
        out_last = last_lane;
        // final lane transferring: input side opens for this cycle only
        if (last_lane && !out_busy) in_busy = 1'b0;
`endif
        if (!out_busy) begin
          adv = 1'b1;
          if (last_lane) begin
`ifdef DOUT_SERIALIZER_CHECKSUM_EN
            state_d = S_SUM;
`else
            load    = in_vld;
            state_d = in_vld ? S_SEND : S_IDLE;
`endif
          end
        end
      end
`ifdef DOUT_SERIALIZER_CHECKSUM_EN
      S_SUM: begin
        out_vld  = 1'b1;
        out_data = chk_q;
        out_chk  = 1'b1;
        out_last = 1'b1;
        in_busy  = out_busy;
        if (!out_busy) begin
          load    = in_vld;
          state_d = in_vld ? S_SEND : S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      hold_q <= in_data;
      cnt_q  <= '0;
    end else if (adv) begin
      cnt_q  <= cnt_inc;
    end
  end

`ifdef DOUT_SERIALIZER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      chk_q <= '0;
    else if (load) chk_q <= '0;
    else if (adv)  chk_q <= chk_q + lane_data;
  end
`endif

endmodule

// File: tb/tb_dout_serializer.sv
module tb_dout_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_busy;
  logic         in_vld;
  logic [255:0] in_data;
  logic         out_busy;
  logic         out_vld;
  logic [15:0]  out_data;
  logic [3:0]   out_idx;
  logic         out_last;
  logic         out_chk;

  dout_serializer #(.LANE_W(16), .LANES(16)) dut (
    .clk(clk), .rst(rst), .in_busy(in_busy), .in_vld(in_vld), .in_data(in_data),
    .out_busy(out_busy), .out_vld(out_vld), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_chk(out_chk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  idx;
    logic        last;
    logic        chk;
  } beat_t;

  beat_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a word becomes 16 lane beats, lane 0 first, plus a checksum
  // beat when the feature is built in.
  function automatic void push_word(input logic [255:0] w);
    beat_t b;
    logic [15:0] sum = 16'd0;
    for (int k = 0; k < 16; k++) begin
      b.d    = w[k*16 +: 16];
      b.idx  = 4'(k);
      b.chk  = 1'b0;
`ifdef DOUT_SERIALIZER_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (k == 15);
`endif
      sum = sum + b.d;
      q.push_back(b);
    end
`ifdef DOUT_SERIALIZER_CHECKSUM_EN
    b.d = sum; b.idx = 4'd0; b.last = 1'b1; b.chk = 1'b1;
    q.push_back(b);
`endif
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic cycle(input bit vld, input logic [255:0] data, input bit ob, output bit acc);
    bit exp_vld, exp_busy;
    in_vld = vld; in_data = data; out_busy = ob;
    @(negedge clk);
    exp_vld = (q.size() != 0);
    check("out_vld", out_vld, exp_vld);
    exp_busy = exp_vld && !(q[0].last && !ob);
    check("in_busy", in_busy, exp_busy);
    if (exp_vld) begin
      check("out_data", out_data, q[0].d);
      check("out_idx",  out_idx,  q[0].idx);
      check("out_last", out_last, q[0].last);
      check("out_chk",  out_chk,  q[0].chk);
      if (!ob) void'(q.pop_front());
    end
    acc = vld && !exp_busy;
    if (acc) push_word(data);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      cycle(1'b0, 256'd0, 1'b0, acc);
      n++;
    end
    check("drain_timeout", n < 100, 1'b1);
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"},  out_vld,  1'b0);
    check({tag, "_busy"}, in_busy,  1'b0);
    check({tag, "_data"}, out_data, 16'd0);
    check({tag, "_idx"},  out_idx,  4'd0);
    check({tag, "_last"}, out_last, 1'b0);
    check({tag, "_chk"},  out_chk,  1'b0);
  endtask

  initial begin
    logic [255:0] w, w2;
    bit acc;
    int n;

    rst = 1'b0; in_vld = 1'b0; in_data = '0; out_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Lanes 1..16, no stall
    for (int k = 0; k < 16; k++) w[k*16 +: 16] = 16'(k + 1);
    cycle(1'b1, w, 1'b0, acc);
    check("seq_accept", acc, 1'b1);
    drain();

    // Stall three cycles at lane 5
    w = rand_word();
    cycle(1'b1, w, 1'b0, acc);
    n = 0;
    while (!(out_vld && out_idx == 4'd5) && n < 40) begin
      cycle(1'b0, 256'd0, 1'b0, acc);
      n++;
    end
    check("reach_idx5", n < 40, 1'b1);
    repeat (3) cycle(1'b0, 256'd0, 1'b1, acc);
    check("stall_data", out_data, w[5*16 +: 16]);
    drain();

    // Back-to-back words
    w  = rand_word();
    w2 = rand_word();
    cycle(1'b1, w, 1'b0, acc);
    n = 0;
    do begin
      cycle(1'b1, w2, 1'b0, acc);
      n++;
    end while (!acc && n < 40);
    check("b2b_accept", acc, 1'b1);
    drain();

    // All lanes 0xFFFF (checksum wrap)
    w = {256{1'b1}};
    cycle(1'b1, w, 1'b0, acc);
    drain();

    // Random traffic with random stalls
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 1) == 1), rand_word(), ($urandom_range(0, 9) < 3), acc);
    drain();

    // Reset mid-word at lane 7
    w = rand_word();
    cycle(1'b1, w, 1'b0, acc);
    n = 0;
    while (!(out_vld && out_idx == 4'd7) && n < 40) begin
      cycle(1'b0, 256'd0, 1'b0, acc);
      n++;
    end
    check("reach_idx7", n < 40, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    @(posedge clk); #1;
    check("midrst_hold_vld", out_vld, 1'b0);
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    w = rand_word();
    cycle(1'b1, w, 1'b0, acc);
    check("post_rst_idx", out_idx, 4'd0);
    check("post_rst_data", out_data, w[15:0]);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
